// File: rtl/hazard_unit_if.sv
// Bundles the hazard unit's pipeline-status inputs and its stall/flush requests.
// The pipeline/controller side uses master; the hazard unit uses slave.
interface hazard_unit_if #(
    parameter int NREGS = 32
);
    logic             if_wait;
    logic             id_valid;
    logic [4:0]       id_rs1;
    logic [4:0]       id_rs2;
    logic             id_uses_rs1;
    logic             id_uses_rs2;
    logic [4:0]       id_rd;
    logic             id_is_load;
    logic             id_wr_en;
    logic             ex_valid;
    logic             ex_is_div;
    logic             ex_mispredict;
    logic             ex_wr_en;
    logic             mem_wait;
    logic             wb_valid;
    logic             wb_is_load;
    logic [4:0]       wb_rd;
    logic             wb_trap;

    logic             if_stall;
    logic             id_stall;
    logic             ex_stall;
    logic             mem_stall;
    logic             wb_stall;
    logic             flush_before_ex;
    logic             flush_before_wb;
    logic [NREGS-1:0] busy_vec;

    modport master (
        output if_wait, id_valid, id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, id_rd,
               id_is_load, id_wr_en, ex_valid, ex_is_div, ex_mispredict, ex_wr_en,
               mem_wait, wb_valid, wb_is_load, wb_rd, wb_trap,
        input  if_stall, id_stall, ex_stall, mem_stall, wb_stall,
               flush_before_ex, flush_before_wb, busy_vec
    );

    modport slave (
        input  if_wait, id_valid, id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, id_rd,
               id_is_load, id_wr_en, ex_valid, ex_is_div, ex_mispredict, ex_wr_en,
               mem_wait, wb_valid, wb_is_load, wb_rd, wb_trap,
        output if_stall, id_stall, ex_stall, mem_stall, wb_stall,
               flush_before_ex, flush_before_wb, busy_vec
    );
endinterface

// File: rtl/hazard_unit.sv
// Stall/flush request generator: load-use scoreboard, multi-cycle divide sequencer,
// and trap/mispredict flush requests for the pipeline traffic controller.
module hazard_unit #(
    parameter int DIV_LATENCY = 8,
    parameter int NREGS       = 32
) (
    input  logic         clk,
    input  logic         reset_n,
    hazard_unit_if.slave hu
);
    localparam int CW = $clog2(DIV_LATENCY);
    // count holds the number of BUSY cycles still to run after the current one
    localparam logic [CW-1:0] BUSY_INIT = CW'((DIV_LATENCY > 2) ? (DIV_LATENCY - 3) : 0);

    typedef enum logic [1:0] {
        DIV_IDLE,
        DIV_BUSY,
        DIV_DONE
    } div_state_t;

    div_state_t       state_q, state_d;
    logic [CW-1:0]    count_q, count_d;
    logic [NREGS-1:0] busy_q, busy_d;

    logic flush_wb;
    logic flush_ex;
    logic wb_load_ret;
    logic hit_rs1;
    logic hit_rs2;
    logic id_stall_c;
    logic issue;
    logic ex_stall_c;

    // A load retiring in WB bypasses its value to ID, so it no longer blocks a reader
    always_comb begin
        flush_wb    = hu.wb_valid & hu.wb_trap;
        flush_ex    = hu.ex_valid & hu.ex_mispredict & ~flush_wb;
        wb_load_ret = hu.wb_valid & hu.wb_is_load;
        hit_rs1     = hu.id_uses_rs1 & (hu.id_rs1 != 5'd0) & busy_q[hu.id_rs1]
                      & ~(wb_load_ret & (hu.wb_rd == hu.id_rs1));
        hit_rs2     = hu.id_uses_rs2 & (hu.id_rs2 != 5'd0) & busy_q[hu.id_rs2]
                      & ~(wb_load_ret & (hu.wb_rd == hu.id_rs2));
        id_stall_c  = hu.id_valid & (hit_rs1 | hit_rs2);
        issue       = hu.id_valid & hu.id_wr_en & ~id_stall_c & ~flush_ex & ~flush_wb;
    end

    // Set after clear so a younger load to the same register keeps it busy
    always_comb begin
        busy_d = busy_q;
        if (wb_load_ret) begin
            busy_d[hu.wb_rd] = 1'b0;
        end
        if (issue & hu.id_is_load & (hu.id_rd != 5'd0)) begin
            busy_d[hu.id_rd] = 1'b1;
        end
        if (flush_wb) begin
            busy_d = '0;
        end
    end

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        ex_stall_c = 1'b0;
        case (state_q)
            DIV_IDLE: begin
                if (hu.ex_valid & hu.ex_is_div) begin
                    ex_stall_c = 1'b1;
                    if (DIV_LATENCY > 2) begin
                        state_d = DIV_BUSY;
                        count_d = BUSY_INIT;
                    end else begin
                        state_d = DIV_DONE;
                    end
                end
            end
            DIV_BUSY: begin
                ex_stall_c = 1'b1;
                if (count_q == '0) begin
                    state_d = DIV_DONE;
                end else begin
                    count_d = count_q - 1'b1;
                end
            end
            DIV_DONE: begin
                if (hu.ex_wr_en) begin
                    state_d = DIV_IDLE;
                end
            end
            default: begin
                state_d = DIV_IDLE;
            end
        endcase
        if (flush_wb) begin
            state_d = DIV_IDLE;
            count_d = '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= DIV_IDLE;
            count_q <= '0;
            busy_q  <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            busy_q  <= busy_d;
        end
    end

    assign hu.if_stall        = hu.if_wait;
    assign hu.id_stall        = id_stall_c;
    assign hu.ex_stall        = ex_stall_c;
    assign hu.mem_stall       = hu.mem_wait;
    assign hu.wb_stall        = 1'b0;
    assign hu.flush_before_ex = flush_ex;
    assign hu.flush_before_wb = flush_wb;
    assign hu.busy_vec        = busy_q;
endmodule

// File: tb/tb_hazard_unit.sv
// Directed bench for hazard_unit: a register-set / divide-age model checked every cycle,
// plus hand-computed literal expectations at key points of each scenario.
module tb_hazard_unit;
    localparam int DIV_LATENCY = 8;
    localparam int NREGS       = 32;

    logic clk = 1'b0;
    logic reset_n;
    int   checks   = 0;
    int   failures = 0;

    hazard_unit_if #(.NREGS(NREGS)) hu ();

    hazard_unit #(
        .DIV_LATENCY(DIV_LATENCY),
        .NREGS      (NREGS)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .hu     (hu)
    );

    always #5 clk = ~clk;

    // Model state: which registers await a load, and how many cycles the divide in EX has spent there
    bit model_busy [NREGS];
    int div_age = -1;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic checkBit(input string name, input logic actual, input logic expected);
        checkOutput(name, {31'b0, actual}, {31'b0, expected});
    endtask

    function automatic bit model_hit(input logic uses, input logic [4:0] r);
        return uses && (r != 5'd0) && model_busy[r]
               && !(hu.wb_valid && hu.wb_is_load && (hu.wb_rd == r));
    endfunction

    function automatic bit exp_fbw();
        return hu.wb_valid && hu.wb_trap;
    endfunction

    function automatic bit exp_fbe();
        return hu.ex_valid && hu.ex_mispredict && !exp_fbw();
    endfunction

    function automatic bit exp_id_stall();
        return hu.id_valid && (model_hit(hu.id_uses_rs1, hu.id_rs1) || model_hit(hu.id_uses_rs2, hu.id_rs2));
    endfunction

    function automatic int cur_div_age();
        if (div_age >= 0) return div_age;
        if (hu.ex_valid && hu.ex_is_div) return 0;
        return -1;
    endfunction

    function automatic bit exp_ex_stall();
        int a;
        a = cur_div_age();
        return (a >= 0) && (a < DIV_LATENCY - 1);
    endfunction

    function automatic logic [NREGS-1:0] exp_busy_vec();
        logic [NREGS-1:0] v;
        v = '0;
        for (int i = 0; i < NREGS; i++) v[i] = model_busy[i];
        return v;
    endfunction

    always @(posedge clk or negedge reset_n) begin : model_update
        int age;
        bit fbw;
        bit iss;
        bit nb [NREGS];
        if (!reset_n) begin
            for (int i = 0; i < NREGS; i++) model_busy[i] <= 1'b0;
            div_age <= -1;
        end else begin
            age = cur_div_age();
            fbw = exp_fbw();
            iss = hu.id_valid && hu.id_wr_en && !exp_id_stall() && !exp_fbe() && !fbw;
            nb  = model_busy;
            if (hu.wb_valid && hu.wb_is_load) nb[hu.wb_rd] = 1'b0;
            if (iss && hu.id_is_load && (hu.id_rd != 5'd0)) nb[hu.id_rd] = 1'b1;
            if (fbw) for (int i = 0; i < NREGS; i++) nb[i] = 1'b0;
            model_busy <= nb;
            if (fbw || age < 0) div_age <= -1;
            else if (age >= DIV_LATENCY - 1 && hu.ex_wr_en) div_age <= -1;
            else if (age >= DIV_LATENCY - 1) div_age <= DIV_LATENCY - 1;
            else div_age <= age + 1;
        end
    end

    always @(negedge clk) begin
        checkBit("if_stall", hu.if_stall, hu.if_wait);
        checkBit("mem_stall", hu.mem_stall, hu.mem_wait);
        checkBit("wb_stall", hu.wb_stall, 1'b0);
        checkBit("id_stall", hu.id_stall, exp_id_stall());
        checkBit("ex_stall", hu.ex_stall, exp_ex_stall());
        checkBit("flush_before_ex", hu.flush_before_ex, exp_fbe());
        checkBit("flush_before_wb", hu.flush_before_wb, exp_fbw());
        checkOutput("busy_vec", hu.busy_vec, exp_busy_vec());
    end

    task automatic clearInputs();
        hu.if_wait       = 1'b0;
        hu.id_valid      = 1'b0;
        hu.id_rs1        = 5'd0;
        hu.id_rs2        = 5'd0;
        hu.id_uses_rs1   = 1'b0;
        hu.id_uses_rs2   = 1'b0;
        hu.id_rd         = 5'd0;
        hu.id_is_load    = 1'b0;
        hu.id_wr_en      = 1'b0;
        hu.ex_valid      = 1'b0;
        hu.ex_is_div     = 1'b0;
        hu.ex_mispredict = 1'b0;
        hu.ex_wr_en      = 1'b0;
        hu.mem_wait      = 1'b0;
        hu.wb_valid      = 1'b0;
        hu.wb_is_load    = 1'b0;
        hu.wb_rd         = 5'd0;
        hu.wb_trap       = 1'b0;
    endtask

    task automatic idLoad(input logic [4:0] rd);
        hu.id_valid   = 1'b1;
        hu.id_is_load = 1'b1;
        hu.id_rd      = rd;
        hu.id_wr_en   = 1'b1;
    endtask

    task automatic sampleWait();
        @(negedge clk);
    endtask

    task automatic applyStimulus();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset_n = 1'b0;
        clearInputs();
        sampleWait();
        checkOutput("rst_busy_vec", hu.busy_vec, 32'h0);
        checkBit("rst_ex_stall", hu.ex_stall, 1'b0);
        checkBit("rst_id_stall", hu.id_stall, 1'b0);
        checkBit("rst_flush_wb", hu.flush_before_wb, 1'b0);
        applyStimulus();
        reset_n = 1'b1;

        // Load-use on x5: stall while the load is in EX and MEM, released by the WB bypass
        idLoad(5'd5);
        sampleWait();
        checkOutput("t1_busy_before", hu.busy_vec, 32'h0);
        applyStimulus();
        clearInputs();
        hu.id_valid = 1'b1; hu.id_rd = 5'd6; hu.id_wr_en = 1'b1;
        hu.id_uses_rs1 = 1'b1; hu.id_rs1 = 5'd5; hu.id_rs2 = 5'd3;
        hu.ex_valid = 1'b1; hu.if_wait = 1'b1;
        sampleWait();
        checkBit("t1_stall_ex", hu.id_stall, 1'b1);
        checkOutput("t1_busy_x5", hu.busy_vec, 32'h0000_0020);
        checkBit("t1_if_stall", hu.if_stall, 1'b1);
        applyStimulus();
        hu.if_wait = 1'b0; hu.ex_valid = 1'b0; hu.mem_wait = 1'b1;
        sampleWait();
        checkBit("t1_stall_mem", hu.id_stall, 1'b1);
        checkBit("t1_mem_stall", hu.mem_stall, 1'b1);
        applyStimulus();
        hu.mem_wait = 1'b0;
        hu.wb_valid = 1'b1; hu.wb_is_load = 1'b1; hu.wb_rd = 5'd5;
        sampleWait();
        checkBit("t1_bypass", hu.id_stall, 1'b0);
        checkOutput("t1_busy_in_wb", hu.busy_vec, 32'h0000_0020);
        applyStimulus();
        clearInputs();
        sampleWait();
        checkOutput("t1_busy_cleared", hu.busy_vec, 32'h0);
        applyStimulus();

        // Divide: ex_stall for cycles 0..6, leaves EX on cycle 7
        for (int k = 0; k < 8; k++) begin
            hu.ex_valid = 1'b1; hu.ex_is_div = 1'b1; hu.ex_wr_en = (k == 7);
            sampleWait();
            checkBit($sformatf("t2_div_stall_c%0d", k), hu.ex_stall, (k < 7));
            applyStimulus();
        end
        // A new divide stalls immediately only if the sequencer went back to idle
        hu.ex_wr_en = 1'b0;
        sampleWait();
        checkBit("t2_idle_again", hu.ex_stall, 1'b1);
        applyStimulus();

        // Trap while the divide is busy and x5/x10 are pending
        idLoad(5'd5);
        sampleWait();
        checkBit("t4_busy_stall1", hu.ex_stall, 1'b1);
        applyStimulus();
        idLoad(5'd10);
        applyStimulus();
        clearInputs();
        hu.ex_valid = 1'b1; hu.ex_is_div = 1'b1;
        hu.wb_valid = 1'b1; hu.wb_trap = 1'b1;
        sampleWait();
        checkOutput("t4_busy_vec", hu.busy_vec, 32'h0000_0420);
        checkBit("t4_flush_wb", hu.flush_before_wb, 1'b1);
        checkBit("t4_stall_busy", hu.ex_stall, 1'b1);
        applyStimulus();
        clearInputs();
        sampleWait();
        checkOutput("t4_busy_flushed", hu.busy_vec, 32'h0);
        checkBit("t4_stall_gone", hu.ex_stall, 1'b0);
        applyStimulus();

        // Divide completes under a 3-cycle D-cache miss
        for (int k = 0; k < 11; k++) begin
            hu.ex_valid = 1'b1; hu.ex_is_div = 1'b1;
            hu.mem_wait = (k >= 7 && k <= 9);
            hu.ex_wr_en = (k == 10);
            sampleWait();
            checkBit($sformatf("t3_div_stall_c%0d", k), hu.ex_stall, (k < 7));
            applyStimulus();
        end
        hu.mem_wait = 1'b0; hu.ex_wr_en = 1'b0;
        sampleWait();
        checkBit("t3_idle_again", hu.ex_stall, 1'b1);
        applyStimulus();

        // Asynchronous reset in the middle of a divide with x9 pending
        idLoad(5'd9);
        applyStimulus();
        hu.id_valid = 1'b0; hu.id_is_load = 1'b0; hu.id_wr_en = 1'b0;
        sampleWait();
        checkOutput("rst2_busy_before", hu.busy_vec, 32'h0000_0200);
        checkBit("rst2_stall_before", hu.ex_stall, 1'b1);
        #2;
        reset_n = 1'b0;
        clearInputs();
        #1;
        checkOutput("rst2_busy_after", hu.busy_vec, 32'h0);
        checkBit("rst2_stall_after", hu.ex_stall, 1'b0);
        applyStimulus();
        reset_n = 1'b1;

        // Mispredict with a load in ID; then mispredict and trap together
        hu.ex_valid = 1'b1; hu.ex_mispredict = 1'b1;
        idLoad(5'd7);
        sampleWait();
        checkBit("t5_flush_ex", hu.flush_before_ex, 1'b1);
        checkBit("t5_no_flush_wb", hu.flush_before_wb, 1'b0);
        applyStimulus();
        hu.wb_valid = 1'b1; hu.wb_trap = 1'b1;
        sampleWait();
        checkOutput("t5_busy_x7_clear", hu.busy_vec, 32'h0);
        checkBit("t5_both_fbw", hu.flush_before_wb, 1'b1);
        checkBit("t5_both_fbe", hu.flush_before_ex, 1'b0);
        applyStimulus();
        clearInputs();

        // Same-register set/clear, rs2 hazard, and a load to x0
        idLoad(5'd3);
        applyStimulus();
        hu.wb_valid = 1'b1; hu.wb_is_load = 1'b1; hu.wb_rd = 5'd3;
        sampleWait();
        checkOutput("t6_busy_x3", hu.busy_vec, 32'h0000_0008);
        applyStimulus();
        clearInputs();
        idLoad(5'd0);
        sampleWait();
        checkOutput("t6_set_wins", hu.busy_vec, 32'h0000_0008);
        applyStimulus();
        clearInputs();
        hu.id_valid = 1'b1; hu.id_uses_rs2 = 1'b1; hu.id_rs2 = 5'd3; hu.id_rd = 5'd4;
        sampleWait();
        checkOutput("t6_x0_ignored", hu.busy_vec, 32'h0000_0008);
        checkBit("t6_rs2_stall", hu.id_stall, 1'b1);
        applyStimulus();
        hu.wb_valid = 1'b1; hu.wb_is_load = 1'b1; hu.wb_rd = 5'd3;
        sampleWait();
        checkBit("t6_rs2_bypass", hu.id_stall, 1'b0);
        applyStimulus();
        clearInputs();
        sampleWait();
        checkOutput("t6_busy_done", hu.busy_vec, 32'h0);
        applyStimulus();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
